// File: rtl/radiant_trig_coinc.sv
// radiant_trig_coinc: per-channel edge detect + stretch, N-of-M coincidence,
// event pulse with descriptor, and a holdoff dead-time state machine.
//
// Ports:
//   clk_i         sole clock
//   rst_n_i       asynchronous active-low reset
//   trig_i        comparator trigger bits (already synchronous to clk_i)
//   enable_i      arms the trigger; low forces DISABLED on the next edge
//   mask_i        1 excludes that channel (applied every cycle)
//   threshold_i   minimum coincident channel count; 0 disables
//   window_i      stretch length in cycles (sampled when a stretch loads)
//   holdoff_i     dead time after an event (sampled when an event fires)
//   event_o       one-cycle event pulse
//   event_info_o  {3'b000, count[4:0], active[23:0]} captured on event_o
//   trig_o        busy level, high exactly while in HOLDOFF
//
// Optional macro RADIANT_TRIG_COINC_DEADCNT_EN adds:
//   dead_clr_i    synchronous clear of the dead counter (wins over increment)
//   dead_cnt_o    saturating count of coincidence cycles seen during HOLDOFF

module radiant_trig_coinc #(
   parameter int NCHAN     = 24,
   parameter int WIN_BITS  = 8,
   parameter int HOLD_BITS = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic [NCHAN-1:0]     trig_i,
   input  logic                 enable_i,
   input  logic [NCHAN-1:0]     mask_i,
   input  logic [4:0]           threshold_i,
   input  logic [WIN_BITS-1:0]  window_i,
   input  logic [HOLD_BITS-1:0] holdoff_i,
`ifdef RADIANT_TRIG_COINC_DEADCNT_EN
   input  logic                 dead_clr_i,
   output logic [15:0]          dead_cnt_o,
`endif
   output logic                 event_o,
   output logic [31:0]          event_info_o,
   output logic                 trig_o
);

   typedef enum logic [1:0] {
      S_DISABLED = 2'd0,
      S_ARMED    = 2'd1,
      S_HOLDOFF  = 2'd2
   } state_t;

   state_t               r_state;
   logic [HOLD_BITS-1:0] r_hold;
   logic                 r_event;
   logic [31:0]          r_info;
   logic                 r_busy;

   logic [NCHAN-1:0]     r_trig_q;
   logic [NCHAN-1:0]     r_rise_q;
   logic [WIN_BITS-1:0]  r_cnt [NCHAN];
   logic [NCHAN-1:0]     r_act_q;
   logic [4:0]           r_cnt_q;

   logic [NCHAN-1:0]     w_act;
   logic [4:0]           w_pop;
   logic                 w_coinc;

   // ------------------------------------------------------------
   // Rising-edge detection
   // ------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_trig_q <= '0;
         r_rise_q <= '0;
      end else begin
         r_trig_q <= trig_i;
         r_rise_q <= trig_i & ~r_trig_q;
      end
   end

   // ------------------------------------------------------------
   // Per-channel stretch counters. A masked rise does not load,
   // so a channel unmasked later only sees fresh edges.
   // ------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < NCHAN; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NCHAN; i++) begin
            if (r_state == S_DISABLED) begin
               r_cnt[i] <= '0;
            end else if (r_rise_q[i] && !mask_i[i]) begin
               r_cnt[i] <= window_i;
            end else if (r_cnt[i] != '0) begin
               r_cnt[i] <= r_cnt[i] - 1'b1;
            end
         end
      end
   end

   // Active in the rise cycle itself plus window_i stretched cycles.
   always_comb begin
      w_act = '0;
      for (int i = 0; i < NCHAN; i++) begin
         w_act[i] = (r_rise_q[i] | (r_cnt[i] != '0)) & ~mask_i[i];
      end
   end

   always_comb begin
      w_pop = '0;
      for (int i = 0; i < NCHAN; i++) begin
         w_pop = w_pop + {4'd0, w_act[i]};
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_act_q <= '0;
         r_cnt_q <= '0;
      end else begin
         r_act_q <= w_act;
         r_cnt_q <= w_pop;
      end
   end

   // Thresholds above the channel count can never be met.
   assign w_coinc = (threshold_i != 5'd0) && (r_cnt_q >= threshold_i);

   // ------------------------------------------------------------
   // Control FSM with registered outputs
   // ------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= S_DISABLED;
         r_hold  <= '0;
         r_event <= 1'b0;
         r_info  <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_event <= 1'b0;
         if (!enable_i) begin
            r_state <= S_DISABLED;
            r_busy  <= 1'b0;
         end else begin
            unique case (r_state)
               S_DISABLED: begin
                  r_state <= S_ARMED;
                  r_busy  <= 1'b0;
               end
               S_ARMED: begin
                  if (w_coinc) begin
                     r_state <= S_HOLDOFF;
                     r_event <= 1'b1;
                     r_hold  <= holdoff_i;
                     r_info  <= {3'b000, r_cnt_q, r_act_q};
                     r_busy  <= 1'b1;
                  end
               end
               S_HOLDOFF: begin
                  // Leave in the cycle after the counter reads 0,
                  // so holdoff_i=0 still gives one HOLDOFF cycle.
                  if (r_hold == '0) begin
                     r_state <= S_ARMED;
                     r_busy  <= 1'b0;
                  end else begin
                     r_hold <= r_hold - 1'b1;
                  end
               end
               default: begin
                  r_state <= S_DISABLED;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign event_o      = r_event;
   assign event_info_o = r_info;
   assign trig_o       = r_busy;

`ifdef RADIANT_TRIG_COINC_DEADCNT_EN
   // ------------------------------------------------------------
   // Dead-time coincidence counter (saturating)
   // ------------------------------------------------------------
   logic [15:0] r_dead;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_dead <= '0;
      end else if (dead_clr_i) begin
         r_dead <= '0;
      end else if ((r_state == S_HOLDOFF) && w_coinc
                   && (r_dead != 16'hFFFF)) begin
         r_dead <= r_dead + 16'd1;
      end
   end

   assign dead_cnt_o = r_dead;
`endif

endmodule

// File: tb/tb_radiant_trig_coinc.sv
// tb_radiant_trig_coinc: directed vector table, hand-written multi-cycle
// sequences and a randomized run against a time-based reference model.
`timescale 1ns/1ps

module tb_radiant_trig_coinc;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [23:0] trig;
   logic        enable;
   logic [23:0] mask;
   logic [4:0]  thr;
   logic [7:0]  win;
   logic [15:0] hold;
   logic        ev;
   logic [31:0] info;
   logic        busy;
`ifdef RADIANT_TRIG_COINC_DEADCNT_EN
   logic        dclr;
   logic [15:0] dcnt;
`endif

   int n_pass = 0;
   int n_chk  = 0;

   always #5 clk = ~clk;

   radiant_trig_coinc dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .trig_i       (trig),
      .enable_i     (enable),
      .mask_i       (mask),
      .threshold_i  (thr),
      .window_i     (win),
      .holdoff_i    (hold),
`ifdef RADIANT_TRIG_COINC_DEADCNT_EN
      .dead_clr_i   (dclr),
      .dead_cnt_o   (dcnt),
`endif
      .event_o      (ev),
      .event_info_o (info),
      .trig_o       (busy)
   );

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench 1ns after an edge, reset released; the next edge is cycle 0.
   task automatic reset_dut();
      rst_n = 1'b0;
      trig  = '0;
`ifdef RADIANT_TRIG_COINC_DEADCNT_EN
      dclr  = 1'b0;
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [4:0]  thr;
      logic [7:0]  win;
      logic [23:0] mask;
      logic [23:0] pa;
      int          ta;
      logic [23:0] pb;
      int          tb;
      int          exp_n;
      int          exp_t;
      logic [31:0] exp_info;
      int          exp_busy;
   } vec_t;

   vec_t vt[9];

   initial begin
      int nev, tev, nb;
      logic [31:0] ginfo;

      rst_n  = 1'b0;
      trig   = '0;
      enable = 1'b1;
      mask   = '0;
      thr    = 5'd1;
      win    = 8'd0;
      hold   = 16'd0;
`ifdef RADIANT_TRIG_COINC_DEADCNT_EN
      dclr   = 1'b0;
`endif
      #1;
      check("reset_event_o", {31'd0, ev}, 32'd0);
      check("reset_info", info, 32'd0);
      check("reset_trig_o", {31'd0, busy}, 32'd0);
`ifdef RADIANT_TRIG_COINC_DEADCNT_EN
      check("reset_dead_cnt", {16'd0, dcnt}, 32'd0);
`endif

      // ---------------- directed vector table (holdoff 8) ----------------
      vt[0] = '{5'd2, 8'd4, 24'h0, 24'h000001, 0, 24'h000020, 3,
                1, 5, 32'h02000021, 9};
      vt[1] = '{5'd2, 8'd4, 24'h0, 24'h000001, 0, 24'h000020, 6,
                0, 0, 32'h0, 0};
      vt[2] = '{5'd1, 8'd4, 24'h000001, 24'h000001, 0, 24'h000001, 4,
                0, 0, 32'h0, 0};
      vt[3] = '{5'd0, 8'd4, 24'h0, 24'hFFFFFF, 0, 24'h0, -1,
                0, 0, 32'h0, 0};
      vt[4] = '{5'd25, 8'd4, 24'h0, 24'hFFFFFF, 0, 24'h0, -1,
                0, 0, 32'h0, 0};
      vt[5] = '{5'd24, 8'd0, 24'h0, 24'hFFFFFF, 0, 24'h0, -1,
                1, 2, 32'h18FFFFFF, 9};
      vt[6] = '{5'd2, 8'd0, 24'h0, 24'h000004, 0, 24'h000008, 1,
                0, 0, 32'h0, 0};
      vt[7] = '{5'd2, 8'd1, 24'h0, 24'h000004, 0, 24'h000008, 1,
                1, 3, 32'h0200000C, 9};
      vt[8] = '{5'd2, 8'd4, 24'h000020, 24'h000001, 0, 24'h000020, 3,
                0, 0, 32'h0, 0};

      for (int v = 0; v < 9; v++) begin
         reset_dut();
         thr  = vt[v].thr;
         win  = vt[v].win;
         mask = vt[v].mask;
         hold = 16'd8;
         enable = 1'b1;
         nev = 0; tev = -1; nb = 0; ginfo = '0;
         for (int k = 0; k < 30; k++) begin
            trig = ((k == vt[v].ta) ? vt[v].pa : 24'h0)
                 | ((k == vt[v].tb) ? vt[v].pb : 24'h0);
            step();
            if (ev) begin
               nev++;
               if (nev == 1) begin
                  tev = k;
                  ginfo = info;
               end
            end
            if (busy) nb++;
         end
         check($sformatf("vec%0d_nevents", v), nev, vt[v].exp_n);
         if (vt[v].exp_n > 0) begin
            check($sformatf("vec%0d_cycle", v), tev, vt[v].exp_t);
            check($sformatf("vec%0d_info", v), ginfo, vt[v].exp_info);
         end
         check($sformatf("vec%0d_busy", v), nb, vt[v].exp_busy);
      end

      // -------- holdoff 10: re-trigger absorbed, next event after holdoff --------
      begin
         int first_t, second_t, nb20, ne20;
         reset_dut();
         thr = 5'd1; win = 8'd2; mask = '0; hold = 16'd10; enable = 1'b1;
         nev = 0; first_t = -1; second_t = -1; nb20 = 0; ne20 = 0;
         for (int k = 0; k < 40; k++) begin
            trig = (k == 0 || k == 5 || k == 25) ? 24'h2 : 24'h0;
            step();
            if (ev) begin
               nev++;
               if (nev == 1) first_t = k;
               if (nev == 2) second_t = k;
               if (k < 20) ne20++;
            end
            if (busy && k < 20) nb20++;
         end
         check("hold10_events_first20", ne20, 1);
         check("hold10_busy_cycles", nb20, 11);
         check("hold10_first_cycle", first_t, 2);
         check("hold10_second_cycle", second_t, 27);
         check("hold10_nevents", nev, 2);
      end

      // -------- holdoff 0: exactly one busy cycle --------
      reset_dut();
      thr = 5'd1; win = 8'd0; mask = '0; hold = 16'd0; enable = 1'b1;
      nev = 0; nb = 0;
      for (int k = 0; k < 10; k++) begin
         trig = (k == 0) ? 24'h8 : 24'h0;
         step();
         if (ev) nev++;
         if (busy) nb++;
      end
      check("hold0_nevents", nev, 1);
      check("hold0_busy_cycles", nb, 1);

      // -------- enable drop mid-holdoff, then async reset --------
      reset_dut();
      thr = 5'd1; win = 8'd0; mask = '0; hold = 16'd20; enable = 1'b1;
      for (int k = 0; k < 6; k++) begin
         trig = (k == 0) ? 24'h1 : 24'h0;
         step();
      end
      check("mid_holdoff_busy", {31'd0, busy}, 32'd1);
      enable = 1'b0;
      step();
      check("disable_busy", {31'd0, busy}, 32'd0);
      check("disable_event", {31'd0, ev}, 32'd0);
      enable = 1'b1;
      step();
      trig = 24'h2;
      step();
      trig = 24'h0;
      step();
      step();
      check("reenable_event", {31'd0, ev}, 32'd1);
      check("reenable_info", info, 32'h01000002);
      check("reenable_busy", {31'd0, busy}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_event", {31'd0, ev}, 32'd0);
      check("async_rst_info", info, 32'd0);
      check("async_rst_busy", {31'd0, busy}, 32'd0);

`ifdef RADIANT_TRIG_COINC_DEADCNT_EN
      // -------- dead counter: 3 coinc cycles in holdoff, clear, saturation --------
      reset_dut();
      thr = 5'd1; win = 8'd3; mask = '0; hold = 16'd20; enable = 1'b1;
      for (int k = 0; k < 11; k++) begin
         trig = (k == 0) ? 24'h1 : 24'h0;
         step();
      end
      check("dead_cnt_three", {16'd0, dcnt}, 32'd3);
      dclr = 1'b1;
      step();
      dclr = 1'b0;
      check("dead_cnt_clear", {16'd0, dcnt}, 32'd0);
      win = 8'd4; hold = 16'hFFFF;
      for (int k = 0; k < 66000; k++) begin
         trig = (k % 2 == 0) ? 24'h1 : 24'h0;
         step();
      end
      check("dead_cnt_sat", {16'd0, dcnt}, 32'h0000FFFF);
      trig = 24'h1;
      step();
      trig = 24'h0;
      check("dead_cnt_sat_hold", {16'd0, dcnt}, 32'h0000FFFF);
      dclr = 1'b1;
      step();
      dclr = 1'b0;
      check("dead_clr_priority", {16'd0, dcnt}, 32'd0);
      trig = 24'h1;
      step();
      trig = 24'h0;
      check("dead_cnt_restart", {16'd0, dcnt}, 32'd1);
`endif

      // -------- randomized run against a time-based model --------
      for (int run = 0; run < 6; run++) begin
         int          last_rise[24];
         logic [23:0] act_hist[300];
         logic [23:0] prev, cur, flip, rise, act;
         logic [31:0] exp_info;
         int          last_ev, p, hv;
         logic        exp_ev, exp_busy;

         reset_dut();
         thr  = 5'($urandom_range(0, 5));
         win  = 8'($urandom_range(0, 6));
         hv   = $urandom_range(0, 12);
         hold = 16'(hv);
         mask = 24'($urandom & $urandom & $urandom);
         enable = 1'b1;
         prev = '0;
         last_ev = -1000;
         exp_info = '0;
         for (int i = 0; i < 24; i++) last_rise[i] = -1000;

         for (int k = 0; k < 300; k++) begin
            flip = 24'($urandom & $urandom & $urandom);
            cur  = prev ^ flip;
            trig = cur;
            rise = cur & ~prev;
            prev = cur;
            act  = '0;
            for (int i = 0; i < 24; i++) begin
               if (rise[i] && !mask[i]) last_rise[i] = k;
               act[i] = !mask[i] && (k - last_rise[i] <= int'(win));
            end
            act_hist[k] = act;

            exp_ev = 1'b0;
            if (k >= 2 && (k - 1 >= last_ev + hv + 1) && thr != 5'd0) begin
               p = $countones(act_hist[k-2]);
               if (p >= int'(thr)) begin
                  exp_ev   = 1'b1;
                  last_ev  = k;
                  exp_info = {3'b000, 5'(p), act_hist[k-2]};
               end
            end
            exp_busy = (k - last_ev) <= hv;

            step();
            check($sformatf("rnd%0d_c%0d_event", run, k), {31'd0, ev},
                  {31'd0, exp_ev});
            check($sformatf("rnd%0d_c%0d_busy", run, k), {31'd0, busy},
                  {31'd0, exp_busy});
            check($sformatf("rnd%0d_c%0d_info", run, k), info, exp_info);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/radiant_trig_coinc.md
RADIANT_TRIG_COINC -- requirements
Module: radiant_trig_coinc

Interface
REQ-001 The module SHALL have parameter NCHAN, default 24, meaning the number of trigger channels; all behaviour below is specified for 24.
REQ-002 The module SHALL have parameter WIN_BITS, default 8, meaning the width of the coincidence window and stretch counters.
REQ-003 The module SHALL have parameter HOLD_BITS, default 16, meaning the width of the holdoff counter.
REQ-004 The module SHALL have one clock, clk_i, and one reset, rst_n_i; reset is asynchronous and active-low.
REQ-005 The module SHALL have the following ports:
- clk_i  input  1: sole clock.
- rst_n_i  input  1: asynchronous active-low reset.
- trig_i  input  24: comparator trigger bits, already synchronized to clk_i.
- enable_i  input  1: arms the trigger.
- mask_i  input  24: 1 excludes that channel.
- threshold_i  input  5: minimum number of coincident channels; 0 disables.
- window_i  input  8: stretch length in clk_i cycles.
- holdoff_i  input  16: dead time after an event, in cycles.
- event_o  output  1: one-cycle event pulse to the event controller.
- event_info_o  output  32: event descriptor, valid from the event_o cycle.
- trig_o  output  1: busy level, high during holdoff.

Function
REQ-006 The module SHALL detect rising edges per channel as rise_q[i] <= trig_i[i] & ~trig_q[i], registered at each clk_i edge.
REQ-007 On rise_q[i]=1 with mask_i[i]=0, stretch counter cnt[i] SHALL load window_i; otherwise a nonzero cnt[i] SHALL decrement by 1.
- A re-trigger while cnt[i] is nonzero SHALL reload window_i.
REQ-008 A channel SHALL be active when (rise_q[i] | cnt[i]!=0) & ~mask_i[i].
- With window_i=0, a channel SHALL be active only in its rise_q cycle.
REQ-009 The active vector SHALL be registered into act_q and its popcount into cnt_q (5 bits) one cycle after rise_q.
REQ-010 The coincidence signal coinc SHALL be (threshold_i != 0) && (cnt_q >= threshold_i).
- threshold_i > 24 SHALL never produce coinc.
REQ-011 The state machine SHALL have three states: DISABLED, ARMED, HOLDOFF.
- DISABLED: event_o=0; all cnt[] held at 0. Go to ARMED on enable_i=1.
- ARMED: when coinc=1, pulse event_o for one cycle, load the holdoff counter with holdoff_i, and go to HOLDOFF.
- HOLDOFF: decrement the holdoff counter; go to ARMED in the cycle after the counter reads 0. holdoff_i=0 SHALL give exactly one HOLDOFF cycle.
- Any state with enable_i=0 SHALL go to DISABLED on the next edge, including mid-holdoff.
REQ-012 Latency SHALL be exactly 2 clk_i cycles from the clk_i edge at which trig_i is first sampled high to event_o=1 (rise_q, then act_q/cnt_q, then event_o).
REQ-013 On event_o, event_info_o SHALL capture [23:0]=act_q, [28:24]=cnt_q, [31:29]=3'b000, and SHALL hold until the next event.
REQ-014 Stretch counters SHALL keep running during HOLDOFF; coinc during HOLDOFF SHALL NOT produce event_o.
REQ-015 trig_o SHALL be 1 exactly while the state is HOLDOFF.
REQ-016 mask_i and threshold_i SHALL be applied combinationally every cycle; window_i and holdoff_i SHALL be sampled only at load time.

Reset
REQ-017 While rst_n_i=0, the module SHALL hold state=DISABLED, event_o=0, event_info_o=0, trig_o=0, and all registers and counters at 0.
REQ-018 Release of rst_n_i SHALL take effect on the first clk_i edge; if enable_i=1 then, the state SHALL enter ARMED on that edge.

Configuration
REQ-019 Macro RADIANT_TRIG_COINC_DEADCNT_EN defined SHALL add input dead_clr_i (1 bit) and output dead_cnt_o (16 bits).
- dead_cnt_o SHALL count cycles with coinc=1 while in HOLDOFF, saturating at 0xFFFF.
- dead_clr_i=1 SHALL zero dead_cnt_o, with clear taking priority over increment.
- dead_cnt_o SHALL reset to 0.
REQ-020 Without RADIANT_TRIG_COINC_DEADCNT_EN, those ports and the counter SHALL be absent, with all other behaviour identical.

Verification
REQ-021 Bench SHALL cover: thr=2, win=4, mask=0; ch0 rises at cycle 0 and ch5 at cycle 3 -> one event_o at cycle 5, event_info_o=0x02000021.
REQ-022 Bench SHALL cover: same setup with ch5 rising at cycle 6 -> no event_o.
REQ-023 Bench SHALL cover: thr=1, holdoff=10; ch1 rises at cycles 0 and 5 -> single event; trig_o high 11 cycles; second event only after holdoff ends.
REQ-024 Bench SHALL cover: mask=0x000001, thr=1; ch0 toggling -> no event; thr=0 or thr=25 with all channels rising -> no event.
REQ-025 Bench SHALL cover: enable_i dropped mid-HOLDOFF, then rst_n_i pulsed low asynchronously -> DISABLED next edge, trig_o=0, and all outputs 0 immediately on reset assertion.
REQ-026 Bench SHALL cover, with RADIANT_TRIG_COINC_DEADCNT_EN: coinc held 3 cycles during HOLDOFF -> dead_cnt_o=3; dead_clr_i -> 0; forcing 0xFFFF then incrementing -> stays 0xFFFF.
